// File: rtl/async_fifo_if.sv
// ============================================================================
// async_fifo_if : producer/consumer handshake bundle for async_fifo
// Revision 1.0
// ============================================================================
`default_nettype none

interface async_fifo_if #(
    parameter int WIDTH = 8
);
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic             full;
    logic             error;

    modport master (
        output wr_en, rd_en, wr_data,
        input  rd_data, empty, full, error
    );

    modport slave (
        input  wr_en, rd_en, wr_data,
        output rd_data, empty, full, error
    );
endinterface

`default_nettype wire

// File: rtl/async_fifo.sv
// ============================================================================
// async_fifo : single-clock FIFO with registered read data and error pulse
// Revision 1.0
// ============================================================================
`default_nettype none

module async_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = 4
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    async_fifo_if.slave bus
);
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_WIDTH:0] r_wp;
    logic [PTR_WIDTH:0] r_rp;
    logic [WIDTH-1:0]   r_rd_data;
    logic               r_error;

    logic               w_empty;
    logic               w_full;
    logic               w_wr_ok;
    logic               w_rd_ok;
    logic               w_reject;

    // Extra MSB on each pointer separates "full" from "empty" when addresses match.
    assign w_empty  = (r_wp == r_rp);
    assign w_full   = (r_wp[PTR_WIDTH-1:0] == r_rp[PTR_WIDTH-1:0]) &&
                      (r_wp[PTR_WIDTH] != r_rp[PTR_WIDTH]);
    assign w_wr_ok  = bus.wr_en && !w_full;
    assign w_rd_ok  = bus.rd_en && !w_empty;
    assign w_reject = (bus.wr_en && w_full) || (bus.rd_en && w_empty);

    always_ff @(posedge clk) begin
        if (rst_n && w_wr_ok) begin
            mem[r_wp[PTR_WIDTH-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_rd_data <= '0;
            r_error   <= 1'b0;
        end else begin
            r_error <= w_reject;
            if (w_wr_ok) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_data <= mem[r_rp[PTR_WIDTH-1:0]];
                r_rp      <= r_rp + 1'b1;
            end
        end
    end

    assign bus.rd_data = r_rd_data;
    assign bus.empty   = w_empty;
    assign bus.full    = w_full;
    assign bus.error   = r_error;
endmodule

`default_nettype wire

// File: tb/tb_async_fifo.sv
// ============================================================================
// tb_async_fifo : directed and randomized-gap checks of async_fifo
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_async_fifo;
    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;

    async_fifo_if #(.WIDTH(8)) bus ();

    async_fifo #(.WIDTH(8), .DEPTH(16), .PTR_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp_data;
        logic [7:0] last_rd;
        logic       exp_wr_ok;
        logic       exp_rd_ok;
        logic       exp_err;
        int         nw;
        int         nr;
        int         wgap;
        int         rgap;
        int         cyc;

        nvec = 0;
        nerr = 0;

        // Reset held with both requests active
        rst_n       = 1'b0;
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b1;
        bus.wr_data = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_empty", 32'(bus.empty), 32'd1);
            check("rst_full", 32'(bus.full), 32'd0);
            check("rst_error", 32'(bus.error), 32'd0);
            check("rst_rd_data", 32'(bus.rd_data), 32'h00);
        end
        rst_n     = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        tick();
        check("post_rst_empty", 32'(bus.empty), 32'd1);
        check("post_rst_error", 32'(bus.error), 32'd0);
        check("post_rst_rd_data", 32'(bus.rd_data), 32'h00);

        // Fill A0..AF
        for (int i = 0; i < 16; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'hA0 + 8'(i);
            tick();
            check("fill_empty", 32'(bus.empty), 32'd0);
            check("fill_full", 32'(bus.full), (i == 15) ? 32'd1 : 32'd0);
            check("fill_error", 32'(bus.error), 32'd0);
        end

        // Overflow write is dropped
        bus.wr_data = 8'h5A;
        tick();
        check("ovf_error", 32'(bus.error), 32'd1);
        check("ovf_full", 32'(bus.full), 32'd1);
        bus.wr_en = 1'b0;
        tick();
        check("ovf_error_clr", 32'(bus.error), 32'd0);
        check("ovf_full_hold", 32'(bus.full), 32'd1);

        // Drain in order
        for (int i = 0; i < 16; i++) begin
            bus.rd_en = 1'b1;
            tick();
            check("drain_data", 32'(bus.rd_data), 32'hA0 + 32'(i));
            check("drain_empty", 32'(bus.empty), (i == 15) ? 32'd1 : 32'd0);
            check("drain_full", 32'(bus.full), 32'd0);
            check("drain_error", 32'(bus.error), 32'd0);
        end

        // Two underflows back to back keep error high
        tick();
        check("udf_error1", 32'(bus.error), 32'd1);
        check("udf_hold1", 32'(bus.rd_data), 32'hAF);
        tick();
        check("udf_error2", 32'(bus.error), 32'd1);
        check("udf_hold2", 32'(bus.rd_data), 32'hAF);
        check("udf_empty", 32'(bus.empty), 32'd1);
        bus.rd_en = 1'b0;
        tick();
        check("udf_error_clr", 32'(bus.error), 32'd0);

        // Simultaneous access while full
        for (int i = 0; i < 16; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'hB0 + 8'(i);
            tick();
        end
        check("b_full", 32'(bus.full), 32'd1);
        bus.wr_data = 8'h77;
        bus.rd_en   = 1'b1;
        tick();
        check("simf_rd_data", 32'(bus.rd_data), 32'hB0);
        check("simf_error", 32'(bus.error), 32'd1);
        check("simf_full", 32'(bus.full), 32'd0);
        bus.wr_en = 1'b0;
        for (int i = 1; i < 16; i++) begin
            tick();
            check("simf_drain", 32'(bus.rd_data), 32'hB0 + 32'(i));
            check("simf_drain_err", 32'(bus.error), 32'd0);
        end
        check("simf_empty", 32'(bus.empty), 32'd1);

        // Simultaneous access while empty
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h3C;
        tick();
        check("sime_rd_hold", 32'(bus.rd_data), 32'hBF);
        check("sime_error", 32'(bus.error), 32'd1);
        check("sime_empty", 32'(bus.empty), 32'd0);
        bus.wr_en = 1'b0;
        tick();
        check("sime_rd_data", 32'(bus.rd_data), 32'h3C);
        check("sime_err_clr", 32'(bus.error), 32'd0);
        check("sime_empty2", 32'(bus.empty), 32'd1);
        bus.rd_en = 1'b0;

        // Reset mid-operation discards contents
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h11;
        tick();
        tick();
        bus.wr_en = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_empty", 32'(bus.empty), 32'd1);
        check("mrst_rd_data", 32'(bus.rd_data), 32'h00);
        tick();

        // Independent random-gap producer and consumer against a queue model
        nw      = 0;
        nr      = 0;
        wgap    = 0;
        rgap    = 0;
        cyc     = 0;
        last_rd = 8'h00;
        while ((nw < 500 || nr < 500) && cyc < 20000) begin
            bus.wr_en   = (wgap == 0) && (nw < 500);
            bus.rd_en   = (rgap == 0) && (nr < 500);
            bus.wr_data = 8'($urandom);
            check("rnd_full", 32'(bus.full), (q.size() == 16) ? 32'd1 : 32'd0);
            check("rnd_empty", 32'(bus.empty), (q.size() == 0) ? 32'd1 : 32'd0);
            exp_wr_ok = bus.wr_en && (q.size() < 16);
            exp_rd_ok = bus.rd_en && (q.size() != 0);
            exp_err   = (bus.wr_en && !exp_wr_ok) || (bus.rd_en && !exp_rd_ok);
            if (exp_rd_ok) begin
                exp_data = q.pop_front();
                last_rd  = exp_data;
            end
            if (exp_wr_ok) q.push_back(bus.wr_data);
            tick();
            check("rnd_error", 32'(bus.error), 32'(exp_err));
            check("rnd_rd_data", 32'(bus.rd_data), 32'(last_rd));
            if (bus.wr_en) begin
                nw++;
                wgap = int'($urandom_range(0, 9));
            end else if (wgap > 0) begin
                wgap--;
            end
            if (bus.rd_en) begin
                nr++;
                rgap = int'($urandom_range(0, 9));
            end else if (rgap > 0) begin
                rgap--;
            end
            cyc++;
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check("rnd_done", 32'(cyc < 20000), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

`default_nettype wire
